// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory initiator: FSM states, RV32 funct3 codes,
// and the access-size decode used by both the store and load paths.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Anything that is not a byte or halfword code (011, 110, 111, 010) is a word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_LB, F3_LBU: sz = SZ_B;
      F3_LH, F3_LHU: sz = SZ_H;
      default:       sz = SZ_W;
    endcase
    return sz;
  endfunction

  // Byte/half loads without the U bit are sign-extended.
  function automatic logic f3_signed(input logic [2:0] f3);
    return !f3[2];
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the byte/halfword at the byte offset within the
// returned word and sign- or zero-extends it. Word accesses pass through raw.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            off_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Logical right shift: a halfword at offset 3 sees zeros in its upper byte.
  logic [DATA_WIDTH-1:0] shifted;
  logic                  sext;

  assign shifted = rdata_i >> {off_i, 3'b000};
  assign sext    = f3_signed(funct3_i);

  // Pick the sub-word and extend it according to funct3.
  always_comb begin
    data_o = rdata_i;
    case (f3_size(funct3_i))
      SZ_B:    data_o = {{(DATA_WIDTH-8){sext & shifted[7]}}, shifted[7:0]};
      SZ_H:    data_o = {{(DATA_WIDTH-16){sext & shifted[15]}}, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU front end: takes one load/store from EXU, issues a single word-aligned
// request to data memory, waits for completion and returns the extended load
// data. One access outstanding at a time.
// Optional build macro MISALIGN_CHK_EN: misaligned H/W accesses skip memory
// and complete with resp_err=1; when undefined resp_err is always 0.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_raddr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [1:0]            off;
  lsu_size_e             size;
  logic [3:0]            st_mask;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] aligned_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  skip_mem;

  assign off          = addr_q[1:0];
  assign size         = f3_size(funct3_q);
  assign aligned_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
  // Stores complete with zero data; loads return the aligned/extended word.
  assign cap_data     = is_store_q ? '0 : ld_data;

`ifdef MISALIGN_CHK_EN
  assign skip_mem = ((size == SZ_H) && addr_q[0]) || ((size == SZ_W) && (off != 2'b00));
`else
  assign skip_mem = 1'b0;
`endif

  // Store lane placement; mask bits shifted past byte 3 fall off the 4-bit vector.
  always_comb begin
    st_mask = 4'hF;
    st_data = wdata_q;
    case (size)
      SZ_B: begin
        st_mask = 4'b0001 << off;
        st_data = {{(DATA_WIDTH-8){1'b0}}, wdata_q[7:0]} << {off, 3'b000};
      end
      SZ_H: begin
        st_mask = 4'b0011 << off;
        st_data = {{(DATA_WIDTH-16){1'b0}}, wdata_q[15:0]} << {off, 3'b000};
      end
      default: begin
        st_mask = 4'hF;
        st_data = wdata_q;
      end
    endcase
  end

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata_i  (mem_rdata),
    .off_i    (off),
    .funct3_i (funct3_q),
    .data_o   (ld_data)
  );

  // Next-state and output decode for the IDLE/REQ/WAIT/RESP handshake.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_ren    = 1'b0;
    mem_raddr  = '0;
    mem_wen    = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_wmask  = 8'h00;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d    = REQ;
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          err_d      = 1'b0;
        end
      end
      REQ: begin
        if (skip_mem) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          if (is_store_q) begin
            mem_wen   = 1'b1;
            mem_waddr = aligned_addr;
            mem_wdata = st_data;
            mem_wmask = {4'b0000, st_mask};
          end else begin
            mem_ren   = 1'b1;
            mem_raddr = aligned_addr;
          end
          if (mem_req_ready) begin
            if (mem_resp_valid) begin
              state_d = RESP;
              rdata_d = cap_data;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d = RESP;
          rdata_d = cap_data;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: table of single-access vectors plus
// hand sequences for stalls, same-cycle response, reset abort and misalign.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic [31:0] exp_maddr;
    logic [7:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Accept at a negedge; the next negedge sees the REQ state.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.st, v.f3, v.addr, v.wdata);
    chk({v.name, "_ren"}, {31'b0, mem_ren}, {31'b0, !v.st});
    chk({v.name, "_wen"}, {31'b0, mem_wen}, {31'b0, v.st});
    if (v.st) begin
      chk({v.name, "_waddr"}, mem_waddr, v.exp_maddr);
      chk({v.name, "_wmask"}, {24'b0, mem_wmask}, {24'b0, v.exp_mask});
      chk({v.name, "_wdata"}, mem_wdata, v.exp_wdata);
    end else begin
      chk({v.name, "_raddr"}, mem_raddr, v.exp_maddr);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk({v.name, "_wait_quiet"}, {30'b0, mem_ren, mem_wen}, 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = v.mrdata;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk({v.name, "_resp_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({v.name, "_rdata"}, resp_rdata, v.exp_rdata);
    chk({v.name, "_err"}, {31'b0, resp_err}, 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({v.name, "_resp_drop"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    //          name     st    f3      addr          wdata         mrdata        maddr         mask   wdata         rdata
    vecs[0]  = '{"lw",    1'b0, 3'b010, 32'h80000004, 32'h0,        32'hDEADBEEF, 32'h80000004, 8'h00, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{"lb3",   1'b0, 3'b000, 32'h80000003, 32'h0,        32'h80FF0011, 32'h80000000, 8'h00, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{"lbu3",  1'b0, 3'b100, 32'h80000003, 32'h0,        32'h80FF0011, 32'h80000000, 8'h00, 32'h0,        32'h00000080};
    vecs[3]  = '{"lhu2",  1'b0, 3'b101, 32'h80000002, 32'h0,        32'h80FF0011, 32'h80000000, 8'h00, 32'h0,        32'h000080FF};
    vecs[4]  = '{"lh2",   1'b0, 3'b001, 32'h80000002, 32'h0,        32'h80FF0011, 32'h80000000, 8'h00, 32'h0,        32'hFFFF80FF};
    vecs[5]  = '{"lh3",   1'b0, 3'b001, 32'h80000003, 32'h0,        32'h80FF0011, 32'h80000000, 8'h00, 32'h0,        32'h00000080};
    vecs[6]  = '{"lb0",   1'b0, 3'b000, 32'h80000000, 32'h0,        32'h80FF0011, 32'h80000000, 8'h00, 32'h0,        32'h00000011};
    vecs[7]  = '{"lw011", 1'b0, 3'b011, 32'h80000008, 32'h0,        32'h12345678, 32'h80000008, 8'h00, 32'h0,        32'h12345678};
    vecs[8]  = '{"sb1",   1'b1, 3'b000, 32'h80000001, 32'h123456AB, 32'h55555555, 32'h80000000, 8'h02, 32'h0000AB00, 32'h0};
    vecs[9]  = '{"sh2",   1'b1, 3'b001, 32'h80000002, 32'h123456AB, 32'h55555555, 32'h80000000, 8'h0C, 32'h56AB0000, 32'h0};
    vecs[10] = '{"sw",    1'b1, 3'b010, 32'h80000008, 32'h12345678, 32'h55555555, 32'h80000008, 8'h0F, 32'h12345678, 32'h0};
    vecs[11] = '{"sh3",   1'b1, 3'b001, 32'h80000003, 32'h123456AB, 32'h55555555, 32'h80000000, 8'h08, 32'hAB000000, 32'h0};
    vecs[12] = '{"sb3",   1'b1, 3'b000, 32'h80000007, 32'h000000CD, 32'h55555555, 32'h80000004, 8'h08, 32'hCD000000, 32'h0};

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_outs", {28'b0, resp_valid, resp_err, mem_ren, mem_wen}, 32'd0);
    chk("rst_wmask", {24'b0, mem_wmask}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Memory stalls 3 cycles, then EXU stalls the response 2 cycles.
    issue(1'b0, 3'b010, 32'h80000010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_ren", {31'b0, mem_ren}, 32'd1);
      chk("stall_raddr", mem_raddr, 32'h80000010);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("stall_ren_last", {31'b0, mem_ren}, 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("stall_wait_quiet", {30'b0, mem_ren, resp_valid}, 32'd0);
    chk("stall_wait_req_ready", {31'b0, req_ready}, 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, 32'hCAFEF00D);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    chk("hold_rdata_last", resp_rdata, 32'hCAFEF00D);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("single_resp0", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("single_resp1", {31'b0, resp_valid}, 32'd0);

    // Response in the same cycle the request is accepted.
    issue(1'b1, 3'b010, 32'h80000020, 32'h0BADF00D);
    chk("fast_wen", {31'b0, mem_wen}, 32'd1);
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk("fast_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("fast_rdata", resp_rdata, 32'd0);
    chk("fast_wen_off", {31'b0, mem_wen}, 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset while waiting; the late memory response must be ignored.
    issue(1'b0, 3'b000, 32'h80000000, 32'h0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h000000AA;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("late_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("late_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk("late_resp_valid2", {31'b0, resp_valid}, 32'd0);

    // Misaligned word load.
    issue(1'b0, 3'b010, 32'h80000002, 32'h0);
`ifdef MISALIGN_CHK_EN
    chk("mis_no_ren", {31'b0, mem_ren}, 32'd0);
    @(negedge clk);
    chk("mis_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err", {31'b0, resp_err}, 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
`else
    chk("mis_ren", {31'b0, mem_ren}, 32'd1);
    chk("mis_raddr", mem_raddr, 32'h80000000);
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk("mis_resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err", {31'b0, resp_err}, 32'd0);
    chk("mis_rdata", resp_rdata, 32'h11223344);
`endif
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("mis_done", {31'b0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
